// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART TX controller with a registered, frame-stable head word
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              not_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_ok, rd_ok;
    assign full      = count == (ADDR_W+1)'(DEPTH);
    assign not_empty = count != '0;
    assign wr_ok     = wr_en & ~full;
    assign rd_ok     = rd_en & not_empty;
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
    // set wins over clr_err so a coincident error is never lost
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            count     <= (wr_ok && !rd_ok) ? count + 1'b1 : (!wr_ok && rd_ok) ? count - 1'b1 : count;
            overflow  <= (wr_en & full) | (overflow & ~clr_err);
            underflow <= (rd_en & ~not_empty) | (underflow & ~clr_err);
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random traffic checked against a queue model of the FIFO
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, not_empty, overflow, underflow;
    logic [7:0] rd_data;
    logic [4:0] count;
    int compared = 0, mismatched = 0;
    logic [7:0] q[$];
    logic [7:0] exp_rd = '0;
    logic       exp_ov = 1'b0, exp_un = 1'b0;
    int pushed;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .rd_en(rd_en), .rd_data(rd_data), .not_empty(not_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".not_empty"}, 32'(not_empty), 32'(q.size() != 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 16));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_un));
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd = '0;
        exp_ov = 1'b0;
        exp_un = 1'b0;
    endtask

    // called #1 after an edge; drives one cycle of inputs, advances model and DUT, then checks
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input string tag);
        bit was_full, was_ne;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        was_full = q.size() == 16;
        was_ne   = q.size() != 0;
        exp_ov = (w && was_full) || (exp_ov && !c);
        exp_un = (r && !was_ne) || (exp_un && !c);
        if (r && was_ne) exp_rd = q.pop_front();
        if (w && !was_full) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_async_count", 32'(count), 0);
        rst = 1'b0;
        step(0, 0, 0, 0, "idle");

        step(1, 8'hA5, 0, 0, "push_a5");
        step(0, 0, 0, 0, "gap");
        step(0, 0, 1, 0, "pop_a5");
        chk("single_rd", 32'(rd_data), 32'h A5);
        repeat (200) begin
            @(posedge clk);
            #1;
        end
        check_all("hold_a5");

        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "fill");
        chk("full_after_16", 32'(full), 1);
        step(1, 8'hFF, 0, 0, "push_full");
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, "drain");
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        step(0, 0, 1, 0, "pop_empty");
        chk("under_hold", 32'(rd_data), 32'h0F);
        step(0, 0, 0, 1, "clr_err");

        pushed = 0;
        while (pushed < 40 || q.size() != 0) begin
            logic w, r;
            w = pushed < 40 && q.size() < 5 && $urandom_range(0, 1) == 1;
            r = q.size() != 0 && ($urandom_range(0, 2) != 0 || pushed == 40);
            step(w, 8'(8'h30 + pushed), r, 0, "wrap");
            if (w) pushed++;
            chk("wrap_max5", 32'(count <= 5), 1);
        end

        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, "refill");
        step(1, 8'h77, 1, 0, "full_wr_rd");
        chk("full_wr_rd_cnt", 32'(count), 15);
        while (q.size() != 0) begin
            step(0, 0, 1, 0, "drain2");
            chk("no_77", 32'(rd_data == 8'h77 && q.size() != 0), 0);
        end
        step(1, 8'h42, 1, 0, "empty_wr_rd");
        chk("empty_wr_rd_cnt", 32'(count), 1);
        step(0, 0, 1, 1, "pop_42");
        chk("pop_42_val", 32'(rd_data), 32'h42);

        repeat (300) begin
            logic [31:0] r32;
            r32 = $urandom;
            step(r32[0] | r32[1], r32[15:8], r32[2] & r32[3], r32[7:4] == 0, "random");
        end

        step(0, 0, 1, 1, "pre_mid");
        while (q.size() > 0) step(0, 0, 1, 0, "empty_mid");
        for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0, 0, "mid_fill");
        step(0, 0, 1, 0, "mid_pop");
        for (int i = 0; i < 1; i++) step(1, 8'hC7, 0, 0, "mid_fill2");
        chk("mid_cnt7", 32'(count), 7);
        rd_en = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_all("in_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 8'h11, 0, 0, "post_push");
        step(0, 0, 1, 0, "post_pop");
        chk("post_rst_val", 32'(rd_data), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
